// File: rtl/alu_exec_mc.sv
// Multi-cycle execute unit for an RV32I/RV32IM core: base ops resolve in one cycle,
// M-extension multiply/divide iterate one bit per clock behind valid/ready handshakes.
module alu_exec_mc #(
    parameter int XLEN = 32,
    parameter bit MEXT = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_class,
    input  logic [3:0]      in_fn,
    input  logic            in_mext,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illeg,
    output logic [1:0]      dbg_state
);

    // Handshake: a request is taken on in_valid && in_ready && !kill; a result
    // leaves on out_valid && out_ready; out_* are held while out_valid && !out_ready.

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, mag_b;
    logic [2:0]      op_f3;
    logic            neg;

    logic            accept;
    logic            dec_illeg, start_mul, start_div;
    logic [XLEN-1:0] dec_res;
    logic [XLEN-1:0] init_lo, init_b;
    logic            init_neg;

    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   hi_n, lo_n, fin_res;
    logic [2*XLEN-1:0] prod, prod_f;
    logic              last;

    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [SW-1:0]          sh;
        logic signed [XLEN-1:0] sa;
        sh  = b[SW-1:0];
        sa  = $signed(a);
        alu = '0;
        case (f3)
            3'b000: alu = alt ? a - b : a + b;
            3'b001: alu = a << sh;
            3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: alu = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100: alu = a ^ b;
            3'b101: begin
                if (alt) alu = sa >>> sh;
                else     alu = a >> sh;
            end
            3'b110: alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !kill;
    assign dbg_state = state_q;

    // Decode and single-cycle results, plus the operand setup for iterative ops.
    always_comb begin
        logic [2:0]      f3;
        logic            a_sgn, b_sgn, sa, sb;
        logic [XLEN-1:0] ma, mb;
        f3        = in_fn[2:0];
        dec_illeg = 1'b0;
        dec_res   = '0;
        start_mul = 1'b0;
        start_div = 1'b0;
        init_lo   = '0;
        init_b    = '0;
        init_neg  = 1'b0;
        a_sgn     = f3[2] ? !f3[0] : (f3 != 3'b011);
        b_sgn     = f3[2] ? !f3[0] : !f3[1];
        sa        = a_sgn && in_a[XLEN-1];
        sb        = b_sgn && in_b[XLEN-1];
        ma        = sa ? -in_a : in_a;
        mb        = sb ? -in_b : in_b;
        case (in_class)
            4'd0, 4'd1, 4'd2: dec_res = in_b;
            4'd3, 4'd4, 4'd5: dec_res = in_a + in_b;
            4'd6: dec_res = alu(f3, in_fn[3] && (f3 == 3'b101), in_a, in_b);
            4'd7: begin
                case (f3)
                    3'b000: dec_res = {{(XLEN-1){1'b0}}, (in_a == in_b)};
                    3'b001: dec_res = {{(XLEN-1){1'b0}}, (in_a != in_b)};
                    3'b100: dec_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
                    3'b101: dec_res = {{(XLEN-1){1'b0}}, ($signed(in_a) >= $signed(in_b))};
                    3'b110: dec_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
                    3'b111: dec_res = {{(XLEN-1){1'b0}}, (in_a >= in_b)};
                    default: dec_illeg = 1'b1;
                endcase
            end
            4'd8: begin
                if (in_mext) begin
                    if (!MEXT || in_fn[3]) begin
                        dec_illeg = 1'b1;
                    end else if (!f3[2]) begin
                        start_mul = 1'b1;
                        init_lo   = mb;
                        init_b    = ma;
                        init_neg  = sa ^ sb;
                    end else if (in_b == '0) begin
                        dec_res = f3[1] ? in_a : '1;
                    end else if (a_sgn && (in_a == MIN_NEG) && (in_b == '1)) begin
                        dec_res = f3[1] ? '0 : in_a;
                    end else begin
                        start_div = 1'b1;
                        init_lo   = ma;
                        init_b    = mb;
                        init_neg  = f3[1] ? sa : (sa ^ sb);
                    end
                end else if (in_fn[3] && (f3 != 3'b000) && (f3 != 3'b101)) begin
                    dec_illeg = 1'b1;
                end else begin
                    dec_res = alu(f3, in_fn[3], in_a, in_b);
                end
            end
            default: dec_illeg = 1'b1;
        endcase
    end

    // One iteration step; acc_hi/acc_lo hold the product or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
        div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, mag_b};
        if (state_q == S_DIV) begin
            hi_n = div_trial[XLEN] ? {acc_hi[XLEN-2:0], acc_lo[XLEN-1]} : div_trial[XLEN-1:0];
            lo_n = {acc_lo[XLEN-2:0], !div_trial[XLEN]};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_f = neg ? -prod : prod;
        if (state_q == S_DIV) begin
            if (op_f3[1]) fin_res = neg ? -hi_n : hi_n;
            else          fin_res = neg ? -lo_n : lo_n;
        end else begin
            fin_res = (op_f3 == 3'b000) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
        end
        last = (cnt == SW'(XLEN-1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && start_mul)      state_d = S_MUL;
                else if (accept && start_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            mag_b      <= '0;
            op_f3      <= '0;
            neg        <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_illeg  <= 1'b0;
        end else if (kill) begin
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_illeg  <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (start_mul || start_div) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= init_lo;
                    mag_b  <= init_b;
                    op_f3  <= in_fn[2:0];
                    neg    <= init_neg;
                end else begin
                    out_valid  <= 1'b1;
                    out_result <= dec_res;
                    out_illeg  <= dec_illeg;
                end
            end else if (state_q != S_IDLE) begin
                acc_hi <= hi_n;
                acc_lo <= lo_n;
                cnt    <= cnt + SW'(1);
                if (last) begin
                    cnt        <= '0;
                    out_valid  <= 1'b1;
                    out_result <= fin_res;
                    out_illeg  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed bench for alu_exec_mc: hand-computed results, latencies, hold, kill and reset abort.
module tb_alu_exec_mc;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_class = '0;
    logic [3:0]  in_fn = '0;
    logic        in_mext = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_illeg;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_mc #(.XLEN(32), .MEXT(1'b1)) dut (
        .clk(clk), .rstn(rstn), .kill(kill),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_fn(in_fn), .in_mext(in_mext),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illeg(out_illeg),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [3:0] f, input logic m,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_class = c; in_fn = f; in_mext = m; in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(output int lat, output int busy_rdy);
        lat = 1;
        busy_rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [3:0] f, input logic m,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input logic exp_ill);
        int lat, busy;
        send(c, f, m, a, b);
        collect(lat, busy);
        chk(tag, out_result, exp);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_ill"}, {31'd0, out_illeg}, {31'd0, exp_ill});
        if (exp_lat > 1) chk({tag, "_rdy_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen, lat, busy;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_illeg", {31'd0, out_illeg}, 32'd0);

        // Back-to-back ADDI then SUB
        in_class = 4'd6; in_fn = 4'b0000; in_mext = 1'b0; in_a = 32'd5; in_b = 32'hFFFF_FFFD;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_addi", out_result, 32'd2);
        chk("b2b_addi_v", {31'd0, out_valid}, 32'd1);
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        in_class = 4'd8; in_fn = 4'b1000; in_a = 32'd5; in_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_sub", out_result, 32'hFFFF_FFFE);
        chk("b2b_sub_v", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_pop", {31'd0, out_valid}, 32'd0);

        run_op("srai",  4'd6, 4'b1101, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b0);
        run_op("srli",  4'd6, 4'b0101, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 1'b0);
        run_op("bltu",  4'd7, 4'b0110, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
        run_op("blt",   4'd7, 4'b0100, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_op("slti",  4'd6, 4'b1010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
        run_op("lui",   4'd0, 4'b0000, 1'b0, 32'h1234, 32'hABCD_E000, 32'hABCD_E000, 1, 1'b0);
        run_op("jalr",  4'd3, 4'b0000, 1'b0, 32'h1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1, 1'b0);
        run_op("ill_cls", 4'd9, 4'b0000, 1'b0, 32'd1, 32'd2, 32'd0, 1, 1'b1);
        run_op("ill_br",  4'd7, 4'b0010, 1'b0, 32'd1, 32'd1, 32'd0, 1, 1'b1);
        run_op("ill_r",   4'd8, 4'b1001, 1'b0, 32'd1, 32'd1, 32'd0, 1, 1'b1);

        run_op("mulh",  4'd8, 4'b0001, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("mul",   4'd8, 4'b0000, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("mulhu", 4'd8, 4'b0011, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("div_ovf", 4'd8, 4'b0100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("remu_z",  4'd8, 4'b0111, 1'b1, 32'd7, 32'd0, 32'd7, 1, 1'b0);
        run_op("divu",    4'd8, 4'b0101, 1'b1, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("div_neg", 4'd8, 4'b0100, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);

        // REM held while the consumer stalls
        out_ready = 1'b0;
        send(4'd8, 4'b0110, 1'b1, 32'hFFFF_FFF9, 32'd2);
        collect(lat, busy);
        chk("rem_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rem_hold", out_result, 32'hFFFF_FFFF);
            chk("rem_hold_v", {31'd0, out_valid}, 32'd1);
            chk("rem_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rem_pop", {31'd0, out_valid}, 32'd0);

        // kill together with a request in IDLE: request ignored
        in_class = 4'd8; in_fn = 4'b0000; in_mext = 1'b0; in_a = 32'd1; in_b = 32'd1;
        in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_req", {31'd0, out_valid}, 32'd0);

        // kill at iteration 10 of DIVU
        send(4'd8, 4'b0101, 1'b1, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_state", {30'd0, dbg_state}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("kill_no_valid", 32'(seen), 32'd0);
        run_op("add_after_kill", 4'd8, 4'b0000, 1'b0, 32'd3, 32'd4, 32'd7, 1, 1'b0);

        // reset at iteration 20 of MUL
        send(4'd8, 4'b0000, 1'b1, 32'd6, 32'd7);
        repeat (20) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rstmid_no_valid", 32'(seen), 32'd0);
        run_op("add_after_rst", 4'd8, 4'b0000, 1'b0, 32'h10, 32'h20, 32'h30, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
